shift_add_ctrl: RTL and testbench

- Sequencing and accumulation stage for the shift-and-add multiplier.
- It sits directly downstream of the multiplier shift register and consumes that register's `zero` and `lsb_b` status outputs.
- It drives the register's `en`, `ld` and `clr` controls, and holds the multiplicand and the 2N-bit product accumulator.
- One multiplier bit is processed per clock, with a start/done handshake to the surrounding logic.

---
 rtl/shift_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_shift_add_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_ctrl
//
// Sequencing and accumulation stage of a shift-and-add multiplier. It drives
// the enable/mode/clear controls of the external multiplier shift register,
// holds the left-shifting multiplicand and accumulates the 2N-bit product,
// consuming one multiplier bit per clock.
//
// Optional feature (compile-time macro):
//   SHIFT_ADD_EARLY_EXIT_EN  - when defined, the TEST phase ends as soon as the
//                              multiplier register reports it is exhausted
//                              (zero = 0). When undefined, zero is ignored and
//                              every multiply takes exactly N TEST cycles.
//
// Ports:
//   clk    in   1    clock, rising edge
//   clr    in   1    asynchronous reset, active low
//   start  in   1    begin a multiply (only sampled in IDLE)
//   a_in   in   N    multiplicand, captured when start is accepted
//   zero   in   1    multiplier register: 1 while contents nonzero
//   lsb_b  in   1    multiplier register: bit 0 of contents
//   en     out  1    multiplier register enable
//   ld     out  1    multiplier register mode: 0 = load, 1 = shift right
//   sclr   out  1    multiplier register clear, active high (= ~clr)
//   busy   out  1    high while in LOAD or TEST
//   done   out  1    one-cycle pulse, p valid in that cycle
//   p      out  2N   product accumulator
// -----------------------------------------------------------------------------
module shift_add_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic           zero,
    input  logic           lsb_b,
    output logic           en,
    output logic           ld,
    output logic           sclr,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        TEST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [2*N-1:0]   mcand;
    logic [CW-1:0]    cnt;
    logic             exit_now;
    logic             last_bit;

`ifdef SHIFT_ADD_EARLY_EXIT_EN
    // Multiplier register already exhausted: remaining bits would add 0.
    assign exit_now = (state == TEST) && !zero;
`else
    logic unused_zero;
    assign unused_zero = zero;
    assign exit_now    = 1'b0;
`endif

    assign last_bit = (cnt == CW'(N - 1));

    // The register must be cleared whenever this block is held in reset.
    assign sclr = ~clr;

    // Register controls are decoded so they act in the same cycle as the
    // status inputs they depend on.
    always_comb begin
        en = 1'b0;
        ld = 1'b0;
        case (state)
            LOAD: en = 1'b1;
            TEST: begin
                if (!exit_now) begin
                    en = 1'b1;
                    ld = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            p     <= '0;
            mcand <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        mcand <= {{N{1'b0}}, a_in};
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    p     <= '0;
                    state <= TEST;
                end
                TEST: begin
                    if (exit_now) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        p     <= p + (lsb_b ? mcand : '0);
                        mcand <= mcand << 1;
                        cnt   <= cnt + CW'(1);
                        if (last_bit) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for shift_add_ctrl. Provides a behavioural multiplier shift
// register around the DUT, applies a table of directed vectors, random
// operands, and hand-written sequences for restart and reset corner cases.
// -----------------------------------------------------------------------------
module tb_shift_add_ctrl;

    localparam int N = 4;

`ifdef SHIFT_ADD_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           clr   = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   a_in  = '0;
    logic           zero;
    logic           lsb_b;
    logic           en;
    logic           ld;
    logic           sclr;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    logic [N-1:0]   breg;
    logic [N-1:0]   b_cur = '0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    shift_add_ctrl #(.N(N)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .a_in  (a_in),
        .zero  (zero),
        .lsb_b (lsb_b),
        .en    (en),
        .ld    (ld),
        .sclr  (sclr),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    // Multiplier shift register that the controller drives.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr)    breg <= '0;
        else if (en) breg <= ld ? (breg >> 1) : b_cur;
    end
    assign zero  = (breg != '0);
    assign lsb_b = breg[0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: derived from the arithmetic and latency rules.
    function automatic int ref_top(input logic [N-1:0] b);
        int k = -1;
        for (int i = 0; i < N; i++) if (b[i]) k = i;
        return k;
    endfunction

    function automatic int ref_latency(input logic [N-1:0] b);
        int k = ref_top(b);
        if (!EARLY)     return N + 2;
        if (k < 0)      return 3;
        if (k < N - 1)  return k + 4;
        return N + 2;
    endfunction

    function automatic int ref_shifts(input logic [N-1:0] b);
        if (!EARLY) return N;
        return ref_top(b) + 1;
    endfunction

    // Runs one multiply; cycle 0 is the cycle in which start is sampled.
    task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b, input bit extra,
                           output int dcyc, output logic [2*N-1:0] pv,
                           output int nsh, output int nld, output int ndn);
        dcyc = -1; pv = '0; nsh = 0; nld = 0; ndn = 0;
        @(negedge clk);
        b_cur = b;
        a_in  = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = N'($urandom);
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (en && !ld) nld++;
            if (en && ld)  nsh++;
            if (done) begin
                ndn++;
                if (dcyc < 0) begin
                    dcyc = c;
                    pv   = p;
                end
            end
            if (dcyc >= 0 && c == dcyc + 2) check("p_hold", p, pv);
            start = extra && (c == 2 || c == 4);
            if (dcyc >= 0 && c >= dcyc + 3) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        int             cyc;
        logic [2*N-1:0] prod;
        int             shifts;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int dcyc, nsh, nld, ndn, d1, d2;
        logic [2*N-1:0] pv;
        logic [N-1:0] ra, rb;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  cyc: 6,            prod: 8'd15,  shifts: EARLY ? 3 : 4};
        vecs[1] = '{a: 4'd15, b: 4'd15, cyc: 6,            prod: 8'd225, shifts: 4};
        vecs[2] = '{a: 4'd9,  b: 4'd0,  cyc: EARLY ? 3 : 6, prod: 8'd0,   shifts: EARLY ? 0 : 4};
        vecs[3] = '{a: 4'd7,  b: 4'd2,  cyc: EARLY ? 5 : 6, prod: 8'd14,  shifts: EARLY ? 2 : 4};
        vecs[4] = '{a: 4'd6,  b: 4'd4,  cyc: 6,            prod: 8'd24,  shifts: EARLY ? 3 : 4};
        vecs[5] = '{a: 4'd1,  b: 4'd8,  cyc: 6,            prod: 8'd8,   shifts: 4};
        vecs[6] = '{a: 4'd0,  b: 4'd15, cyc: 6,            prod: 8'd0,   shifts: 4};

        // Reset values
        #1 clr = 1'b0;
        #1;
        check("rst_p",    p,    0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_en",   en,   0);
        check("rst_ld",   ld,   0);
        check("rst_sclr", sclr, 1);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("idle_sclr", sclr, 0);

        // Directed vectors
        foreach (vecs[i]) begin
            do_mult(vecs[i].a, vecs[i].b, 1'b0, dcyc, pv, nsh, nld, ndn);
            check($sformatf("v%0d_p", i),      pv,   vecs[i].prod);
            check($sformatf("v%0d_cyc", i),    dcyc, vecs[i].cyc);
            check($sformatf("v%0d_shift", i),  nsh,  vecs[i].shifts);
            check($sformatf("v%0d_load", i),   nld,  1);
            check($sformatf("v%0d_ndone", i),  ndn,  1);
        end

        // Random operands against the reference model
        for (int i = 0; i < 30; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            do_mult(ra, rb, 1'b0, dcyc, pv, nsh, nld, ndn);
            check($sformatf("r%0d_p", i),     pv,   ra * rb);
            check($sformatf("r%0d_cyc", i),   dcyc, ref_latency(rb));
            check($sformatf("r%0d_shift", i), nsh,  ref_shifts(rb));
            check($sformatf("r%0d_ndone", i), ndn,  1);
        end

        // start pulsed again while busy: ignored
        do_mult(4'd3, 4'd5, 1'b1, dcyc, pv, nsh, nld, ndn);
        check("restart_p",     pv,   15);
        check("restart_cyc",   dcyc, 6);
        check("restart_ndone", ndn,  1);
        check("restart_load",  nld,  1);
        repeat (10) @(negedge clk);
        check("restart_idle_busy", busy, 0);

        // start held high: a new multiply every N+3 cycles
        d1 = -1; d2 = -1;
        @(negedge clk);
        b_cur = 4'd15;
        a_in  = 4'd2;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("hold_p_c%0d", c), p, 30);
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        start = 1'b0;
        check("hold_done1", d1, N + 2);
        check("hold_done2", d2, 2 * N + 5);
        repeat (12) @(negedge clk);

        // Reset in the middle of a multiply
        @(negedge clk);
        b_cur = 4'd7;
        a_in  = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_busy", busy, 1);
        clr = 1'b0;
        #1;
        check("abort_p",    p,    0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_en",   en,   0);
        check("abort_ld",   ld,   0);
        check("abort_sclr", sclr, 1);
        ndn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndn++;
        end
        clr = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) ndn++;
        end
        check("abort_stray_done", ndn, 0);
        do_mult(4'd6, 4'd4, 1'b0, dcyc, pv, nsh, nld, ndn);
        check("post_abort_p",     pv,   24);
        check("post_abort_cyc",   dcyc, ref_latency(4'd4));
        check("post_abort_ndone", ndn,  1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
